// File: rtl/mda_crtc_regs.sv
// MC6845-compatible CRTC register file, mode and status ports for the mono text display (0x3B0-0x3BF).
// Latency: writes update controls on the sampling edge; read data is registered, one cycle after iIoRd.
// Backpressure: none; one access per cycle is accepted back-to-back with no stall.
//
// Ports:
//   iClk, iRst           CPU clock and synchronous active-high reset
//   iAddr/iData          I/O port address and write data
//   iIoWr/iIoRd          single-cycle write/read strobes
//   oData/oRdValid       read data and its one-cycle qualifier (oData idles at 0xFF)
//   iHBlank/iVBlank      asynchronous blanking flags from the video clock domain
//   oStartAddr..oCharBlink  registered display controls toward the video generator
module mda_crtc_regs #(
  parameter int BLINK_BITS = 5  // must be at least 5: blink phases use cnt[3] and cnt[4]
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iIoWr,
  input  logic        iIoRd,
  output logic [7:0]  oData,
  output logic        oRdValid,
  input  logic        iHBlank,
  input  logic        iVBlank,
  output logic [13:0] oStartAddr,
  output logic [13:0] oCursorAddr,
  output logic [4:0]  oCursorStart,
  output logic [1:0]  oCursorMode,
  output logic [4:0]  oCursorEnd,
  output logic        oVideoEnable,
  output logic        oBlinkEnable,
  output logic        oCursorBlink,
  output logic        oCharBlink
);

  // Port decode
  logic       claimed;
  logic [3:0] off;
  logic       sel_idx, sel_dat, sel_mode, sel_stat;

  // CRTC state. Only the registers with a consumer are held: R0-R9 and
  // R16-R17 are accepted on the bus, but the video generator runs fixed
  // MDA timing and the light pen is absent, so those writes are discarded.
  logic [4:0] index;
  logic [6:0] r10;
  logic [4:0] r11;
  logic [5:0] r12;
  logic [7:0] r13;
  logic [5:0] r14;
  logic [7:0] r15;

  // Mode register: bit 0 (high-res clock select) has no consumer here,
  // so only video enable (bit 3) and blink enable (bit 5) are kept.
  logic mode_video, mode_blink;

  // Blanking synchronisers and vertical-blank edge detector
  logic hb_m, hb_s;
  logic vb_m, vb_s, vb_d;
  logic vb_rise;

  logic [BLINK_BITS-1:0] cnt;

  logic [7:0] rd_mux;
  logic [7:0] rd_data;
  logic       rd_vld;

  always_comb begin
    claimed  = (iAddr[15:4] == 12'h03B);
    off      = iAddr[3:0];
    // Offsets 0-7 alternate index/data, mirroring the 6845's partial decode.
    sel_idx  = claimed && !off[3] && !off[0];
    sel_dat  = claimed && !off[3] &&  off[0];
    sel_mode = claimed && (off == 4'h8);
    sel_stat = claimed && (off == 4'hA);
  end

  // Read mux sees pre-write register values, so a same-cycle write+read
  // returns the old contents.
  always_comb begin
    rd_mux = 8'hFF;
    if (sel_idx) begin
      rd_mux = {3'b000, index};
    end else if (sel_dat) begin
      case (index)
        5'd14:   rd_mux = {2'b00, r14};
        5'd15:   rd_mux = r15;
        default: rd_mux = 8'h00;  // start address, light pen and timing regs are not readable
      endcase
    end else if (sel_stat) begin
      rd_mux = {4'hF, vb_s, 2'b00, hb_s};
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      index      <= '0;
      r10        <= '0;
      r11        <= '0;
      r12        <= '0;
      r13        <= '0;
      r14        <= '0;
      r15        <= '0;
      mode_video <= 1'b0;
      mode_blink <= 1'b0;
    end else if (iIoWr) begin
      if (sel_idx) begin
        index <= iData[4:0];
      end
      if (sel_dat) begin
        case (index)
          5'd10:   r10 <= iData[6:0];
          5'd11:   r11 <= iData[4:0];
          5'd12:   r12 <= iData[5:0];
          5'd13:   r13 <= iData;
          5'd14:   r14 <= iData[5:0];
          5'd15:   r15 <= iData;
          default: ;
        endcase
      end
      if (sel_mode) begin
        mode_video <= iData[3];
        mode_blink <= iData[5];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      hb_m <= 1'b0;
      hb_s <= 1'b0;
      vb_m <= 1'b0;
      vb_s <= 1'b0;
      vb_d <= 1'b0;
    end else begin
      hb_m <= iHBlank;
      hb_s <= hb_m;
      vb_m <= iVBlank;
      vb_s <= vb_m;
      vb_d <= vb_s;
    end
  end

  assign vb_rise = vb_s && !vb_d;

  // One count per frame; wraps naturally at 2**BLINK_BITS.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt <= '0;
    end else if (vb_rise) begin
      cnt <= cnt + BLINK_BITS'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_data <= 8'hFF;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld  <= iIoRd;
      rd_data <= iIoRd ? rd_mux : 8'hFF;
    end
  end

  always_comb begin
    case (r10[6:5])
      2'b00:   oCursorBlink = 1'b1;
      2'b01:   oCursorBlink = 1'b0;
      2'b10:   oCursorBlink = cnt[3];
      default: oCursorBlink = cnt[4];
    endcase
  end

  assign oData        = rd_data;
  assign oRdValid     = rd_vld;
  assign oStartAddr   = {r12, r13};
  assign oCursorAddr  = {r14, r15};
  assign oCursorStart = r10[4:0];
  assign oCursorMode  = r10[6:5];
  assign oCursorEnd   = r11;
  assign oVideoEnable = mode_video;
  assign oBlinkEnable = mode_blink;
  assign oCharBlink   = cnt[4];

endmodule

// File: tb/tb_mda_crtc_regs.sv
// Self-checking bench for mda_crtc_regs: directed steps plus random port traffic
// compared against a behavioural model of the CRTC register file and frame counter.
// Checks happen one delta after each rising edge.
module tb_mda_crtc_regs;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [15:0] iAddr;
  logic [7:0]  iData;
  logic        iIoWr, iIoRd;
  logic [7:0]  oData;
  logic        oRdValid;
  logic        iHBlank, iVBlank;
  logic [13:0] oStartAddr, oCursorAddr;
  logic [4:0]  oCursorStart, oCursorEnd;
  logic [1:0]  oCursorMode;
  logic        oVideoEnable, oBlinkEnable, oCursorBlink, oCharBlink;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [7:0] m_reg [0:17];
  logic [4:0] m_idx;
  logic [7:0] m_mode;
  int         m_frames;

  mda_crtc_regs #(.BLINK_BITS(5)) dut (
    .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iData(iData),
    .iIoWr(iIoWr), .iIoRd(iIoRd), .oData(oData), .oRdValid(oRdValid),
    .iHBlank(iHBlank), .iVBlank(iVBlank),
    .oStartAddr(oStartAddr), .oCursorAddr(oCursorAddr),
    .oCursorStart(oCursorStart), .oCursorMode(oCursorMode),
    .oCursorEnd(oCursorEnd), .oVideoEnable(oVideoEnable),
    .oBlinkEnable(oBlinkEnable), .oCursorBlink(oCursorBlink),
    .oCharBlink(oCharBlink)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 18; i++) m_reg[i] = 8'h00;
    m_idx    = 5'd0;
    m_mode   = 8'h00;
    m_frames = 0;
  endtask

  function automatic logic [7:0] reg_mask(input int idx);
    if (idx == 10) return 8'h7F;
    if (idx == 11) return 8'h1F;
    if (idx == 12 || idx == 14) return 8'h3F;
    return 8'hFF;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int o;
    if (a[15:4] != 12'h03B) return 8'hFF;
    o = int'(a[3:0]);
    if (o < 8 && (o % 2) == 0) return {3'b000, m_idx};
    if (o < 8) begin
      if (m_idx == 14 || m_idx == 15) return m_reg[m_idx];
      return 8'h00;
    end
    if (o == 10) return 8'hF0 + (iVBlank ? 8'd8 : 8'd0) + (iHBlank ? 8'd1 : 8'd0);
    return 8'hFF;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int o;
    if (a[15:4] != 12'h03B) return;
    o = int'(a[3:0]);
    if (o < 8 && (o % 2) == 0) m_idx = d[4:0];
    else if (o < 8) begin
      if (m_idx < 18) m_reg[m_idx] = d & reg_mask(int'(m_idx));
    end else if (o == 8) m_mode = d & 8'h29;
  endtask

  function automatic logic char_exp(input int frames);
    return ((frames / 16) % 2) == 1;
  endfunction

  function automatic logic cur_exp();
    case (m_reg[10] / 32)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return ((m_frames / 8) % 2) == 1;
      default: return ((m_frames / 16) % 2) == 1;
    endcase
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, ":start"},  oStartAddr,   m_reg[12] * 256 + m_reg[13]);
    chk({tag, ":cursor"}, oCursorAddr,  m_reg[14] * 256 + m_reg[15]);
    chk({tag, ":cstart"}, oCursorStart, m_reg[10] % 32);
    chk({tag, ":cmode"},  oCursorMode,  m_reg[10] / 32);
    chk({tag, ":cend"},   oCursorEnd,   m_reg[11]);
    chk({tag, ":video"},  oVideoEnable, (m_mode / 8) % 2);
    chk({tag, ":blinke"}, oBlinkEnable, (m_mode / 32) % 2);
    chk({tag, ":curblk"}, oCursorBlink, cur_exp());
    chk({tag, ":chrblk"}, oCharBlink,   char_exp(m_frames));
  endtask

  // One bus cycle; called right after an edge+1, returns at the next edge+1.
  task automatic bus(input bit wr, input bit rd, input logic [15:0] a,
                     input logic [7:0] d, input string tag);
    logic [7:0] exp_rd;
    exp_rd = model_read(a);
    iAddr = a; iData = d; iIoWr = wr; iIoRd = rd;
    @(posedge iClk); #1;
    iIoWr = 1'b0; iIoRd = 1'b0;
    if (wr) model_write(a, d);
    chk({tag, ":vld"}, oRdValid, rd);
    chk({tag, ":data"}, oData, rd ? exp_rd : 8'hFF);
    chk_outputs(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // One frame: checks the counter steps exactly on the 3rd edge after the rise.
  task automatic vpulse();
    iVBlank = 1'b1;
    idle(2);
    chk("vb_pre", oCharBlink, char_exp(m_frames));
    idle(1);
    m_frames++;
    chk("vb_post", oCharBlink, char_exp(m_frames));
    chk("vb_cur", oCursorBlink, cur_exp());
    idle(7);
    iVBlank = 1'b0;
    idle(6);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    iRst = 1'b1; iAddr = 16'h0; iData = 8'h0; iIoWr = 1'b0; iIoRd = 1'b0;
    iHBlank = 1'b0; iVBlank = 1'b0;
    model_reset();
    idle(3);
    chk("rst:data", oData, 8'hFF);
    chk("rst:vld", oRdValid, 1'b0);
    chk_outputs("rst");
    chk("rst:curblk1", oCursorBlink, 1'b1);
    iRst = 1'b0;

    // Read R14 after reset
    bus(1, 0, 16'h03B4, 8'h0E, "idx14");
    bus(0, 1, 16'h03B5, 8'h00, "rd14rst");
    bus(0, 0, 16'h0000, 8'h00, "idle1");

    // Cursor address
    bus(1, 0, 16'h03B4, 8'h0E, "w_i14");
    bus(1, 0, 16'h03B5, 8'hFF, "w_r14");
    bus(1, 0, 16'h03B4, 8'h0F, "w_i15");
    bus(1, 0, 16'h03B5, 8'h34, "w_r15");
    chk("cursor3f34", oCursorAddr, 14'h3F34);
    bus(1, 0, 16'h03B4, 8'h0E, "w_i14b");
    bus(0, 1, 16'h03B5, 8'h00, "rd14");
    bus(0, 1, 16'h03B4, 8'h00, "rdidx");

    // Start address: writable, not readable; index >= 18 dropped
    bus(1, 0, 16'h03B4, 8'h0C, "w_i12");
    bus(1, 0, 16'h03B5, 8'h12, "w_r12");
    bus(1, 0, 16'h03B2, 8'h0D, "w_i13");
    bus(1, 0, 16'h03B7, 8'h80, "w_r13");
    chk("start1280", oStartAddr, 14'h1280);
    bus(0, 1, 16'h03B5, 8'h00, "rd13");
    bus(1, 0, 16'h03B6, 8'h0C, "w_i12b");
    bus(0, 1, 16'h03B3, 8'h00, "rd12");
    bus(1, 0, 16'h03B4, 8'h14, "w_i20");
    bus(1, 0, 16'h03B5, 8'hAA, "w_r20");
    bus(0, 1, 16'h03B5, 8'h00, "rd20");

    // Mode register
    bus(1, 1, 16'h03B8, 8'hFF, "w_mode");
    bus(0, 1, 16'h03B8, 8'h00, "rd_mode");

    // Frame counter / blink, fast cursor blink
    bus(1, 0, 16'h03B4, 8'h0A, "w_i10");
    bus(1, 0, 16'h03B5, 8'h40, "w_r10");
    for (int i = 0; i < 16; i++) begin
      vpulse();
      if (i == 7) chk("curblk8", oCursorBlink, 1'b1);
    end
    chk("chrblk16", oCharBlink, 1'b1);
    chk("curblk16", oCursorBlink, 1'b0);
    chk_outputs("frames16");

    // Status port
    iHBlank = 1'b1; iVBlank = 1'b0;
    idle(4);
    bus(0, 1, 16'h03BA, 8'h00, "stat_h");
    chk("stat_f1", oData, 8'hF1);
    iVBlank = 1'b1;
    idle(4);
    m_frames++;
    bus(0, 1, 16'h03BA, 8'h00, "stat_hv");
    chk("stat_f9", oData, 8'hF9);
    iHBlank = 1'b0; iVBlank = 1'b0;
    idle(4);
    bus(0, 1, 16'h03BA, 8'h00, "stat_0");

    // Same-cycle write and read
    bus(1, 0, 16'h03B4, 8'h0F, "w_i15b");
    bus(1, 1, 16'h03B5, 8'h56, "wr_r15");
    chk("wr_old34", oData, 8'h34);
    bus(0, 1, 16'h03B5, 8'h00, "rd_r15");
    chk("rd_new56", oData, 8'h56);
    bus(0, 1, 16'h03B8, 8'h00, "rd_3b8");
    bus(0, 1, 16'h03C0, 8'h00, "rd_3c0");

    // Random traffic
    iHBlank = 1'($urandom_range(0, 1));
    idle(4);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        8:       a = 16'h03C0 + 16'($urandom_range(0, 15));
        9: begin
          a = 16'($urandom);
          if (a[15:4] == 12'h03B) a[15] = 1'b1;
        end
        default: a = 16'h03B0 + 16'($urandom_range(0, 15));
      endcase
      d = 8'($urandom);
      if (a[15:4] == 12'h03B && a[3] == 1'b0 && a[0] == 1'b0 && $urandom_range(0, 3) != 0)
        d = 8'($urandom_range(10, 15));
      bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, "rand");
      if (i % 25 == 24) vpulse();
    end

    // Reset beats a same-cycle write
    bus(1, 0, 16'h03B4, 8'h0F, "pre_i15");
    bus(1, 0, 16'h03B5, 8'h77, "pre_r15");
    iRst = 1'b1; iIoWr = 1'b1; iIoRd = 1'b1; iAddr = 16'h03B5; iData = 8'h99;
    @(posedge iClk); #1;
    iRst = 1'b0; iIoWr = 1'b0; iIoRd = 1'b0;
    model_reset();
    chk("rstwr:vld", oRdValid, 1'b0);
    chk("rstwr:data", oData, 8'hFF);
    chk_outputs("rstwr");
    bus(0, 1, 16'h03B4, 8'h00, "rstwr_idx");
    bus(1, 0, 16'h03B4, 8'h0F, "rstwr_i15");
    bus(0, 1, 16'h03B5, 8'h00, "rstwr_r15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
